// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port synchronous RAM.
package ram_pkg;

  // Controller state: sweeping the array to INIT_VAL, or serving port accesses.
  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_READY = 1'b1
  } ram_state_t;

  // Values for RD_MODE: what a read returns when it hits the word being written.
  localparam int RD_FIRST = 0;  // old data
  localparam int WR_FIRST = 1;  // new data

endpackage

// File: rtl/ram_array.sv
// Storage core: one write port, one registered read port.
// The array itself has no reset; only the read register does.
module ram_array
  import ram_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 4,
  parameter int RD_MODE = RD_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Next read data: hold unless a read is requested; write-first mode
  // forwards the incoming word on a same-address collision.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      if (RD_MODE == WR_FIRST && we && (waddr == raddr))
        rdata_d = wdata;
      else
        rdata_d = mem[raddr];
    end
  end

  // Array write; a read in the same cycle sees the pre-edge contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_dp_sync.sv
// Dual-port synchronous RAM with registered read, read-valid pulse and
// a clear sequencer that sweeps every word to INIT_VAL.
module ram_dp_sync
  import ram_pkg::*;
#(
  parameter int              DATA_W         = 4,
  parameter int              ADDR_W         = 4,
  parameter int              RD_MODE        = RD_FIRST,
  parameter int              CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VAL     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] dataIN,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              clear_req,
  output logic [DATA_W-1:0] dataOut,
  output logic              dataValid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;

  // Next state, sweep counter and write-port mux: the sweep owns the write
  // port while clearing, user ports are gated off until READY.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_we    = 1'b0;
    arr_waddr = wr_addr;
    arr_wdata = dataIN;
    arr_re    = 1'b0;
    case (state_q)
      RAM_CLEAR: begin
        arr_we    = 1'b1;
        arr_waddr = cnt_q;
        arr_wdata = INIT_VAL;
        cnt_d     = cnt_q + 1'b1;  // wraps to 0 after the last word
        if (cnt_q == CNT_LAST) state_d = RAM_READY;
      end
      RAM_READY: begin
        arr_we = write_en;
        arr_re = read_en;
        // Accesses in the request cycle still go through.
        if (clear_req) begin
          state_d = RAM_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = RAM_READY;
    endcase
    busy_d  = (state_d == RAM_CLEAR);
    valid_d = arr_re;
  end

  // Controller registers; busy and valid are registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_READY;
      cnt_q   <= '0;
      busy_q  <= (CLEAR_ON_RESET != 0);
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_MODE(RD_MODE)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .re   (arr_re),
    .raddr(rd_addr),
    .rdata(dataOut)
  );

  assign dataValid = valid_q;
  assign busy      = busy_q;

endmodule

// File: doc/ram_dp_sync.md
Name: ram_dp_sync

Overview:
- Parametrised successor to the 4-bit single-port RAM in the 4-bit computer datapath.
- Separate write and read ports, registered read with a valid flag, and a selectable read-during-write mode.
- A built-in clear sequencer sweeps the array to a known value after reset or on request.
- Serves as data/program memory for the CPU core; the default configuration is the 4-bit x 16-word case.

Parameters:
- DATA_W, 4, data word width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- RD_MODE, 0, same-address read/write collision: 0 = read-first (old data), 1 = write-first (new data)
- CLEAR_ON_RESET, 1, 1 = run a clear sweep after reset release; 0 = come up ready with array contents undefined
- INIT_VAL, 0, DATA_W-bit value written to every word by a clear sweep

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- write_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- dataIN  in  DATA_W  write data
- read_en  in  1  read strobe
- rd_addr  in  ADDR_W  read address
- clear_req  in  1  single-cycle request to re-clear the whole array
- dataOut  out  DATA_W  registered read data
- dataValid  out  1  one-cycle pulse: dataOut updated this cycle
- busy  out  1  clear sweep in progress; port accesses ignored

Behaviour:
- Reset values:
  - dataOut = 0, dataValid = 0, sweep counter = 0.
  - busy = CLEAR_ON_RESET; state = CLEAR if CLEAR_ON_RESET, else READY.
  - The array itself is not reset.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes INIT_VAL to word[cnt], then increments cnt.
  - After writing word DEPTH-1, moves to READY; cnt wraps to 0.
  - Sweep takes exactly DEPTH cycles; busy = 1 throughout, falls on the first READY cycle.
- READY:
  - clear_req = 1 moves to CLEAR next cycle; cnt = 0, busy = 1 from that cycle.
  - A write/read presented in the same cycle as clear_req is still performed.
- Write: in READY, write_en = 1 writes dataIN to word[wr_addr] at the clock edge.
- Read:
  - In READY, read_en = 1 samples rd_addr; dataOut updates and dataValid = 1 on the next edge (latency 1).
  - With read_en = 0: dataValid = 0 and dataOut holds its last value.
- Collision (read_en and write_en in the same cycle, rd_addr == wr_addr):
  - RD_MODE = 0: dataOut returns the pre-write content.
  - RD_MODE = 1: dataOut returns dataIN.
  - Different addresses: independent, no interaction.
- While busy:
  - write_en and read_en are ignored: no array change, dataValid stays 0, dataOut holds.
  - clear_req is ignored; the sweep does not restart.
- Reset mid-sweep or mid-operation: everything returns to reset values at once. With CLEAR_ON_RESET = 1, the sweep restarts from word 0 after release.
- Width rules: addresses are unsigned; no out-of-range case exists (DEPTH = 2**ADDR_W). cnt is ADDR_W bits wide, with terminal detection at cnt == DEPTH-1.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Package ram_pkg holds:
  - enum ram_state_t {RAM_CLEAR, RAM_READY}
  - constants RD_FIRST = 0 and WR_FIRST = 1 for RD_MODE
- Sub-module ram_array: a pure storage core with one write port and one registered read port, parametrised on DATA_W, ADDR_W and RD_MODE.
- ram_dp_sync holds:
  - the FSM and sweep counter
  - muxing of sweep writes versus user writes into ram_array's write port
  - dataValid generation and the busy gating

Test Plan:
- Reset and clear (defaults, INIT_VAL = 0):
  - Pulse rst, then release → busy = 1 for exactly 16 cycles, then 0.
  - Read all 16 addresses → every word 0, each with a dataValid pulse one cycle after read_en.
- Basic write/read:
  - Write 9@0, 5@1, 2@3; then read 1, 0, 3 → dataOut 5, 9, 2 on consecutive cycles, dataValid = 1 on each.
  - Idle cycle afterwards → dataValid = 0, dataOut holds 2.
- Collision:
  - With word 7 = 4, write 0xA@7 and read 7 in the same cycle.
  - RD_MODE = 0 → dataOut = 4; RD_MODE = 1 → dataOut = 0xA.
  - Next read of 7 returns 0xA in both modes.
- Busy gating:
  - During a sweep, write 0xF@2 and read 2 → dataValid stays 0, dataOut unchanged.
  - After the sweep, read 2 → 0 (INIT_VAL).
- clear_req:
  - With words loaded 1..15, pulse clear_req → busy for 16 cycles, then all words read INIT_VAL (run with INIT_VAL = 3).
  - A second clear_req during busy is ignored: total busy time is still 16 cycles.
- Reset mid-sweep and generics:
  - Assert rst at sweep cycle 6 → outputs go to reset values immediately; after release the sweep restarts and lasts 16 full cycles.
  - Repeat the basic write/read scenario with DATA_W = 8, ADDR_W = 6 (64-cycle sweep), using writes 0xA5@63 and 0x3C@0 → reads return 0xA5 and 0x3C.
